axi_read_arbiter: RTL and testbench

- Single-outstanding AXI-Lite read master: the read-direction counterpart of the block's AXI-Lite write path.
- Serves two local requesters: the maestro (high priority) and the control FSM (low priority).
- Arbitrates them, issues one AR transaction at a time, captures the R beat and returns data/status to the winner.
- Sits between the maestro/FSM logic and the AXI-Lite interconnect, next to the write master.

---
 rtl/axi_read_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Single-outstanding AXI-Lite read master arbitrating maestro (high priority) and control FSM requesters.
// Optional read timeout is compiled in with `define AXI_READ_TIMEOUT_EN.
module axi_read_arbiter #(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    // AXI-Lite master, read channels
    output logic [31:0] o_ar_addr,
    output logic        o_ar_valid,
    input  logic        i_ar_ready,
    input  logic [31:0] i_r_data,
    input  logic [1:0]  i_r_resp,
    input  logic        i_r_valid,
    output logic        o_r_ready,
    // AXI-Lite master, write channels held inactive
    output logic        o_aw_valid,
    output logic        o_w_valid,
    output logic        o_b_ready,
    // maestro requester
    input  logic [31:0] maestro_adress_i,
    input  logic        maestro_req_i,
    output logic [31:0] maestro_data_o,
    output logic        maestro_ack_o,
    output logic        maestro_err_o,
    // control FSM requester
    input  logic [31:0] fsm_adress_i,
    input  logic        fsm_req_i,
    output logic [31:0] fsm_data_o,
    output logic        fsm_ack_o,
    output logic        fsm_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_grant;
    logic [31:0] r_ar_addr;
    logic        r_ar_valid;
    logic        r_r_ready;

    logic        w_arb;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_done_data;
    logic        w_done_err;

    // Index 1 = maestro, index 0 = FSM; matches the grant bit encoding.
    logic [1:0]  w_ack;
    logic [1:0]  w_err;
    logic [31:0] w_data [2];

    // The ack cycle is spent in IDLE without arbitrating, so a requester can drop req first.
    assign w_arb   = (r_state == S_IDLE) && (w_ack == 2'b00) && (maestro_req_i || fsm_req_i);
    assign w_ar_hs = (r_state == S_ADDR) && r_ar_valid && i_ar_ready;
    assign w_r_hs  = (r_state == S_DATA) && r_r_ready && i_r_valid;
    assign w_done  = w_r_hs || w_timeout;

`ifdef AXI_READ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] r_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_arb) begin
            r_timer <= '0;
        end else if (r_state != S_IDLE) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // A real R beat in the expiry cycle wins over the timeout.
    assign w_timeout   = (r_state != S_IDLE) && (r_timer == TW'(TIMEOUT_CYCLES - 1)) && !w_r_hs;
    assign w_done_data = w_r_hs ? i_r_data : ERR_DATA;
    assign w_done_err  = w_r_hs ? (i_r_resp != 2'b00) : 1'b1;
`else
    assign w_timeout   = 1'b0;
    assign w_done_data = i_r_data;
    assign w_done_err  = (i_r_resp != 2'b00);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_arb) w_state_next = S_ADDR;
            S_ADDR: begin
                if (w_timeout)    w_state_next = S_IDLE;
                else if (w_ar_hs) w_state_next = S_DATA;
            end
            S_DATA: if (w_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
        end else if (w_done) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
        end else if (w_arb) begin
            r_grant    <= maestro_req_i;
            r_ar_addr  <= maestro_req_i ? maestro_adress_i : fsm_adress_i;
            r_ar_valid <= 1'b1;
        end else if (w_ar_hs) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic        r_ack;
            logic        r_err;
            logic [31:0] r_data;
            logic        w_mine;

            assign w_mine = w_done && (r_grant == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ack  <= 1'b0;
                    r_err  <= 1'b0;
                    r_data <= '0;
                end else begin
                    r_ack <= w_mine;
                    if (w_mine) begin
                        r_data <= w_done_data;
                        r_err  <= w_done_err;
                    end
                end
            end

            assign w_ack[gi]  = r_ack;
            assign w_err[gi]  = r_err;
            assign w_data[gi] = r_data;
        end
    endgenerate

    assign o_ar_addr      = r_ar_addr;
    assign o_ar_valid     = r_ar_valid;
    assign o_r_ready      = r_r_ready;
    assign o_aw_valid     = 1'b0;
    assign o_w_valid      = 1'b0;
    assign o_b_ready      = 1'b0;
    assign maestro_ack_o  = w_ack[1];
    assign maestro_err_o  = w_err[1];
    assign maestro_data_o = w_data[1];
    assign fsm_ack_o      = w_ack[0];
    assign fsm_err_o      = w_err[0];
    assign fsm_data_o     = w_data[0];

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: vector table plus scoreboard of expected completions,
// with hand-written sequences for simultaneous requests, mid-transaction reset and (if compiled) timeout.
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] o_ar_addr;
    logic        o_ar_valid;
    logic        i_ar_ready;
    logic [31:0] i_r_data;
    logic [1:0]  i_r_resp;
    logic        i_r_valid;
    logic        o_r_ready;
    logic        o_aw_valid;
    logic        o_w_valid;
    logic        o_b_ready;
    logic [31:0] maestro_adress_i;
    logic        maestro_req_i;
    logic [31:0] maestro_data_o;
    logic        maestro_ack_o;
    logic        maestro_err_o;
    logic [31:0] fsm_adress_i;
    logic        fsm_req_i;
    logic [31:0] fsm_data_o;
    logic        fsm_ack_o;
    logic        fsm_err_o;

    always #5 clk = ~clk;

    axi_read_arbiter #(
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_ar_addr        (o_ar_addr),
        .o_ar_valid       (o_ar_valid),
        .i_ar_ready       (i_ar_ready),
        .i_r_data         (i_r_data),
        .i_r_resp         (i_r_resp),
        .i_r_valid        (i_r_valid),
        .o_r_ready        (o_r_ready),
        .o_aw_valid       (o_aw_valid),
        .o_w_valid        (o_w_valid),
        .o_b_ready        (o_b_ready),
        .maestro_adress_i (maestro_adress_i),
        .maestro_req_i    (maestro_req_i),
        .maestro_data_o   (maestro_data_o),
        .maestro_ack_o    (maestro_ack_o),
        .maestro_err_o    (maestro_err_o),
        .fsm_adress_i     (fsm_adress_i),
        .fsm_req_i        (fsm_req_i),
        .fsm_data_o       (fsm_data_o),
        .fsm_ack_o        (fsm_ack_o),
        .fsm_err_o        (fsm_err_o)
    );

    typedef struct {
        bit          who_m;
        logic [31:0] addr;
        int          ar_wait;
        int          r_wait;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    typedef struct {
        bit          who_m;
        logic [31:0] data;
        bit          err;
        int          lat;
    } exp_t;

    int          n_pass  = 0;
    int          n_total = 0;
    exp_t        sb[$];
    logic [31:0] mdl_data [2];
    bit          mdl_err  [2];
    vec_t        vecs     [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_req(input bit who_m, input logic [31:0] addr, input bit v);
        if (who_m) begin
            maestro_req_i = v;
            if (v) maestro_adress_i = addr;
        end else begin
            fsm_req_i = v;
            if (v) fsm_adress_i = addr;
        end
    endtask

    // Called at the negedge of the cycle in which the winner's request is presented (cycle 0).
    task automatic serve(input vec_t v);
        exp_t e;
        exp_t g;
        int   cyc;
        bit   seen;
        e.who_m = v.who_m;
        e.data  = v.rdata;
        e.err   = (v.rresp != 2'b00);
        e.lat   = v.ar_wait + v.r_wait + 3;
        sb.push_back(e);
        cyc = 0;
        @(negedge clk); cyc++;
        chk("ar_valid_issue", 32'(o_ar_valid), 32'd1);
        chk("ar_addr_issue", o_ar_addr, v.addr);
        for (int i = 0; i < v.ar_wait; i++) begin
            @(negedge clk); cyc++;
            chk("ar_valid_hold", 32'(o_ar_valid), 32'd1);
            chk("ar_addr_stable", o_ar_addr, v.addr);
        end
        i_ar_ready = 1'b1;
        @(negedge clk); cyc++;
        i_ar_ready = 1'b0;
        chk("ar_valid_drop", 32'(o_ar_valid), 32'd0);
        chk("r_ready_up", 32'(o_r_ready), 32'd1);
        for (int i = 0; i < v.r_wait; i++) begin
            @(negedge clk); cyc++;
            chk("r_ready_hold", 32'(o_r_ready), 32'd1);
        end
        i_r_valid = 1'b1;
        i_r_data  = v.rdata;
        i_r_resp  = v.rresp;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk); cyc++;
            i_r_valid = 1'b0;
            i_r_data  = $urandom;
            i_r_resp  = 2'b00;
            if (maestro_ack_o || fsm_ack_o) seen = 1'b1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL ack_wait: no ack within 16 cycles of r_valid (addr %h)", v.addr);
            set_req(v.who_m, 32'h0, 1'b0);
        end else begin
            g = sb.pop_front();
            chk("ack_latency", 32'(cyc), 32'(g.lat));
            chk("r_ready_drop", 32'(o_r_ready), 32'd0);
            mdl_data[g.who_m] = g.data;
            mdl_err[g.who_m]  = g.err;
            chk("maestro_ack", 32'(maestro_ack_o), 32'(g.who_m));
            chk("fsm_ack", 32'(fsm_ack_o), 32'(!g.who_m));
            chk("maestro_data", maestro_data_o, mdl_data[1]);
            chk("maestro_err", 32'(maestro_err_o), 32'(mdl_err[1]));
            chk("fsm_data", fsm_data_o, mdl_data[0]);
            chk("fsm_err", 32'(fsm_err_o), 32'(mdl_err[0]));
            $display("read who=%s addr=%h data=%h err=%0d lat=%0d", g.who_m ? "maestro" : "fsm",
                     v.addr, g.data, g.err, cyc);
            set_req(g.who_m, 32'h0, 1'b0);
            @(negedge clk);
            chk("ack_one_cycle", 32'({maestro_ack_o, fsm_ack_o}), 32'd0);
        end
    endtask

    initial begin
        int cyc;
        bit seen;
        vec_t v;
        vecs[0] = '{1'b1, 32'h0000_1000, 0, 0, 32'h1234_5678, 2'b00};
        vecs[1] = '{1'b0, 32'h0000_2000, 5, 3, 32'hA5A5_A5A5, 2'b10};
        vecs[2] = '{1'b1, 32'h0000_0004, 1, 0, 32'hCAFE_0004, 2'b11};
        vecs[3] = '{1'b0, 32'h0000_0008, 0, 2, 32'h0000_0808, 2'b00};
        vecs[4] = '{1'b1, 32'h0000_000C, 2, 1, 32'h7777_000C, 2'b01};
        mdl_data[0] = '0; mdl_data[1] = '0;
        mdl_err[0]  = 1'b0; mdl_err[1] = 1'b0;

        rst_n = 1'b0;
        i_ar_ready = 1'b0; i_r_valid = 1'b0; i_r_data = '0; i_r_resp = '0;
        maestro_req_i = 1'b0; maestro_adress_i = '0;
        fsm_req_i = 1'b0; fsm_adress_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_ar_valid", 32'(o_ar_valid), 32'd0);
        chk("rst_r_ready", 32'(o_r_ready), 32'd0);
        chk("rst_ar_addr", o_ar_addr, 32'd0);
        chk("rst_acks", 32'({maestro_ack_o, fsm_ack_o}), 32'd0);
        chk("rst_wr_chan", 32'({o_aw_valid, o_w_valid, o_b_ready}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            set_req(vecs[k].who_m, vecs[k].addr, 1'b1);
            serve(vecs[k]);
        end

        // Simultaneous requests: maestro first, FSM in the following arbitration.
        set_req(1'b1, 32'h10, 1'b1);
        set_req(1'b0, 32'h20, 1'b1);
        v = '{1'b1, 32'h10, 0, 0, 32'h1111_0010, 2'b00};
        serve(v);
        v = '{1'b0, 32'h20, 0, 0, 32'h0BAD_0020, 2'b10};
        serve(v);

        // Reset asserted while in DATA must clear outputs without waiting for a clock.
        set_req(1'b1, 32'h300, 1'b1);
        @(negedge clk);
        i_ar_ready = 1'b1;
        @(negedge clk);
        i_ar_ready = 1'b0;
        chk("pre_rst_in_data", 32'(o_r_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ar_valid", 32'(o_ar_valid), 32'd0);
        chk("arst_r_ready", 32'(o_r_ready), 32'd0);
        chk("arst_acks", 32'({maestro_ack_o, fsm_ack_o}), 32'd0);
        chk("arst_errs", 32'({maestro_err_o, fsm_err_o}), 32'd0);
        chk("arst_maestro_data", maestro_data_o, 32'd0);
        chk("arst_fsm_data", fsm_data_o, 32'd0);
        set_req(1'b1, 32'h0, 1'b0);
        mdl_data[0] = '0; mdl_data[1] = '0;
        mdl_err[0]  = 1'b0; mdl_err[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        v = '{1'b0, 32'h400, 1, 1, 32'h4040_4040, 2'b00};
        set_req(v.who_m, v.addr, 1'b1);
        serve(v);

`ifdef AXI_READ_TIMEOUT_EN
        // Slave accepts AR but never returns R: timeout completion 8 cycles after AR issue.
        set_req(1'b1, 32'h500, 1'b1);
        cyc = 0;
        @(negedge clk); cyc++;
        chk("to_ar_valid", 32'(o_ar_valid), 32'd1);
        i_ar_ready = 1'b1;
        @(negedge clk); cyc++;
        i_ar_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk); cyc++;
            if (maestro_ack_o || fsm_ack_o) seen = 1'b1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL timeout_ack: no ack within 30 cycles");
        end else begin
            chk("to_latency", 32'(cyc), 32'd9);
            chk("to_maestro_ack", 32'(maestro_ack_o), 32'd1);
            chk("to_maestro_data", maestro_data_o, 32'hDEAD_BEEF);
            chk("to_maestro_err", 32'(maestro_err_o), 32'd1);
            chk("to_r_ready", 32'(o_r_ready), 32'd0);
            $display("read who=maestro addr=00000500 timeout lat=%0d", cyc);
        end
        mdl_data[1] = 32'hDEAD_BEEF;
        mdl_err[1]  = 1'b1;
        set_req(1'b1, 32'h0, 1'b0);
        @(negedge clk);
        v = '{1'b1, 32'h600, 0, 0, 32'h0600_0600, 2'b00};
        set_req(v.who_m, v.addr, 1'b1);
        serve(v);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
